// File: rtl/hwpe_stream_burst_scheduler.sv
// Round-robin burst scheduler: one granted input owns the output stream for a full burst.
// Define HWPE_STREAM_BURST_SCHEDULER_PRIO_EN to give stream 0 fixed priority over the rotation.
module hwpe_stream_burst_scheduler #(
  parameter int NB_IN           = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int BURST_CNT_WIDTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic                             enable_i,
  input  logic [BURST_CNT_WIDTH-1:0]       burst_len_i,
  input  logic [NB_IN-1:0]                 req_mask_i,
  input  logic [NB_IN-1:0]                 push_valid_i,
  input  logic [NB_IN*DATA_WIDTH-1:0]      push_data_i,
  input  logic [NB_IN*(DATA_WIDTH/8)-1:0]  push_strb_i,
  output logic [NB_IN-1:0]                 push_ready_o,
  output logic                             pop_valid_o,
  output logic [DATA_WIDTH-1:0]            pop_data_o,
  output logic [DATA_WIDTH/8-1:0]          pop_strb_o,
  input  logic                             pop_ready_i,
  output logic [NB_IN-1:0]                 grant_o,
  output logic                             busy_o,
  output logic                             burst_done_o,
  output logic                             state_o
);

  localparam int IDX_W  = (NB_IN > 1) ? $clog2(NB_IN) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  // Stream handshake: a beat moves on a cycle where pop_valid_o and pop_ready_i are both high;
  // the granted push_ready_o mirrors pop_ready_i, all other inputs see ready low.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [NB_IN-1:0]           grant_q;
  logic [IDX_W-1:0]           gidx_q;
  logic [IDX_W-1:0]           ptr_q;
  logic [BURST_CNT_WIDTH-1:0] cnt_q;
  logic [BURST_CNT_WIDTH-1:0] len_q;
  logic                       done_q;

  logic [NB_IN-1:0]           req;
  logic                       win_found;
  logic [IDX_W-1:0]           win_idx;
  logic [IDX_W:0]             cand_sum;
  logic                       handshake;
  logic                       last_beat;
  logic                       grant_load;
  logic                       burst_end;

  assign req = push_valid_i & req_mask_i;

  // Scan upward from ptr+1 with wrap; the first requester wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    for (int off = 1; off <= NB_IN; off++) begin
      cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (cand_sum >= (IDX_W+1)'(NB_IN)) cand_sum = cand_sum - (IDX_W+1)'(NB_IN);
      if (!win_found && req[cand_sum[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_sum[IDX_W-1:0];
      end
    end
`ifdef HWPE_STREAM_BURST_SCHEDULER_PRIO_EN
    if (req[0]) win_idx = '0;
`endif
  end

  // grant_q is zero outside BURST, so the mux and readys fall to zero in IDLE on their own.
  always_comb begin
    pop_valid_o = 1'b0;
    pop_data_o  = '0;
    pop_strb_o  = '0;
    for (int i = 0; i < NB_IN; i++) begin
      if (grant_q[i]) begin
        pop_valid_o = push_valid_i[i];
        pop_data_o  = push_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        pop_strb_o  = push_strb_i[i*STRB_W +: STRB_W];
      end
    end
  end

  assign push_ready_o = grant_q & {NB_IN{pop_ready_i}};
  assign handshake    = pop_valid_o & pop_ready_i;
  // A latched length of 0 wraps to all-ones here, giving 2^BURST_CNT_WIDTH beats.
  assign last_beat    = (cnt_q == len_q - BURST_CNT_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    burst_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i && win_found) begin
          state_d    = BURST;
          grant_load = 1'b1;
        end
      end
      BURST: begin
        if (handshake && last_beat) begin
          state_d   = IDLE;
          burst_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      grant_q <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ptr_q   <= IDX_W'(NB_IN-1);
      done_q  <= 1'b0;
    end else begin
      done_q <= burst_end;
      if (grant_load) begin
        grant_q <= {{(NB_IN-1){1'b0}}, 1'b1} << win_idx;
        gidx_q  <= win_idx;
        len_q   <= burst_len_i;
        cnt_q   <= '0;
      end else if (burst_end) begin
        grant_q <= '0;
        cnt_q   <= '0;
`ifdef HWPE_STREAM_BURST_SCHEDULER_PRIO_EN
        if (gidx_q != '0) ptr_q <= gidx_q;
`else
        ptr_q <= gidx_q;
`endif
      end else if (handshake) begin
        cnt_q <= cnt_q + BURST_CNT_WIDTH'(1);
      end
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = (state_q == BURST);
  assign burst_done_o = done_q;
  assign state_o      = (state_q == BURST);

endmodule

// File: tb/tb_hwpe_stream_burst_scheduler.sv
// Directed bench for hwpe_stream_burst_scheduler: per-cycle vector table plus stall and long-burst sequences.
module tb_hwpe_stream_burst_scheduler;

  localparam int NB = 4;
  localparam int DW = 32;
  localparam int CW = 4;

  logic           clk;
  logic           rst;
  logic           clear;
  logic           enable;
  logic [CW-1:0]  burst_len;
  logic [NB-1:0]  req_mask;
  logic [NB-1:0]  push_valid;
  logic [NB*DW-1:0]     push_data;
  logic [NB*(DW/8)-1:0] push_strb;
  logic [NB-1:0]  push_ready;
  logic           pop_valid;
  logic [DW-1:0]  pop_data;
  logic [DW/8-1:0] pop_strb;
  logic           pop_ready;
  logic [NB-1:0]  grant;
  logic           busy;
  logic           burst_done;
  logic           state;

  hwpe_stream_burst_scheduler #(
    .NB_IN(NB), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable),
    .burst_len_i(burst_len), .req_mask_i(req_mask),
    .push_valid_i(push_valid), .push_data_i(push_data), .push_strb_i(push_strb),
    .push_ready_o(push_ready),
    .pop_valid_o(pop_valid), .pop_data_o(pop_data), .pop_strb_o(pop_strb),
    .pop_ready_i(pop_ready),
    .grant_o(grant), .busy_o(busy), .burst_done_o(burst_done), .state_o(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each source emits {stream id, own beat count}; the count advances on its own handshake.
  logic [15:0] src_cnt [NB];
  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (rst) src_cnt[i] <= '0;
      else if (push_valid[i] && push_ready[i]) src_cnt[i] <= src_cnt[i] + 16'd1;
    end
  end

  always_comb begin
    push_data = '0;
    push_strb = '0;
    for (int i = 0; i < NB; i++) begin
      push_data[i*DW +: DW]       = {16'(i), src_cnt[i]};
      push_strb[i*(DW/8) +: DW/8] = 4'(i + 1);
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          chk;
    logic          rst, clr, en;
    logic [CW-1:0] len;
    logic [NB-1:0] mask, vld;
    logic          rdy;
    logic [NB-1:0] egnt;
    logic          ebusy, edone;
    int            esrc, eseq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic chk, input logic r, input logic c, input logic en,
                                  input logic [CW-1:0] len, input logic [NB-1:0] mask,
                                  input logic [NB-1:0] vld, input logic rdy,
                                  input logic [NB-1:0] egnt, input logic ebusy, input logic edone,
                                  input int esrc, input int eseq);
    vec_t v;
    v.chk = chk; v.rst = r; v.clr = c; v.en = en; v.len = len; v.mask = mask; v.vld = vld;
    v.rdy = rdy; v.egnt = egnt; v.ebusy = ebusy; v.edone = edone; v.esrc = esrc; v.eseq = eseq;
    vecs.push_back(v);
  endfunction

  // driver tasks
  task automatic do_reset(input logic [CW-1:0] len, input logic [NB-1:0] vld);
    @(negedge clk);
    rst = 1'b1; clear = 1'b0; enable = 1'b1; burst_len = len;
    req_mask = 4'hF; push_valid = vld; pop_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic sb_beat(input string name, inout int beats);
    if (pop_valid && pop_ready) begin
      beats++;
      if (exp_q.size() == 0) check({name, "_extra_beat"}, pop_data, 32'hDEAD_BEEF);
      else check({name, "_data"}, pop_data, exp_q.pop_front());
    end
  endtask

  logic [11:0] v_pat;
  logic [11:0] r_pat;

  initial begin
    vec_t v;
    logic [NB-1:0] eready;
    int beats, beats_first;

    rst = 1'b1; clear = 1'b0; enable = 1'b0; burst_len = '0;
    req_mask = '0; push_valid = '0; pop_ready = 1'b0;

    // Reset with all inputs valid, then a 3-beat rotation 0,1,2,3,0.
    add_vec(0, 1, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 1, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    for (int b = 0; b < 5; b++) begin
      add_vec(1, 0, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h0, 0, (b > 0), 0, 0);
      for (int k = 0; k < 3; k++)
        add_vec(1, 0, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'(1 << (b % 4)), 1, 0, b % 4, 3 * (b / 4) + k);
    end
    add_vec(1, 0, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h0, 0, 1, 0, 0);

    // Only stream 2 requests; it is re-granted, then masked, then held off by enable.
    add_vec(0, 1, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h4, 1, 0, 2, 0);
    add_vec(1, 0, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h4, 1, 0, 2, 1);
    add_vec(1, 0, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h0, 0, 1, 0, 0);
    add_vec(1, 0, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h4, 1, 0, 2, 2);
    add_vec(1, 0, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h4, 1, 0, 2, 3);
    add_vec(1, 0, 0, 1, 4'd2, 4'hB, 4'h4, 1, 4'h0, 0, 1, 0, 0);
    add_vec(1, 0, 0, 1, 4'd2, 4'hB, 4'h4, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd2, 4'hB, 4'h4, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 4'd2, 4'hF, 4'h4, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 0, 4'd2, 4'hF, 4'h4, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd2, 4'hF, 4'h4, 1, 4'h4, 1, 0, 2, 4);

    // clear_i mid-burst on stream 2: no done pulse, next grant restarts at stream 0.
    add_vec(0, 1, 0, 1, 4'd3, 4'h4, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd3, 4'h4, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd3, 4'h4, 4'hF, 1, 4'h4, 1, 0, 2, 0);
    add_vec(1, 0, 1, 1, 4'd3, 4'h4, 4'hF, 1, 4'h4, 1, 0, 2, 1);
    add_vec(1, 0, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h1, 1, 0, 0, 0);
    add_vec(1, 0, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h1, 1, 0, 0, 1);
    add_vec(1, 0, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h1, 1, 0, 0, 2);
    add_vec(1, 0, 0, 1, 4'd3, 4'hF, 4'hF, 1, 4'h0, 0, 1, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      @(negedge clk);
      rst = v.rst; clear = v.clr; enable = v.en; burst_len = v.len;
      req_mask = v.mask; push_valid = v.vld; pop_ready = v.rdy;
      #1;
      if (v.chk) begin
        eready = (v.ebusy && v.rdy) ? v.egnt : 4'h0;
        check($sformatf("v%0d_grant", k), 32'(grant), 32'(v.egnt));
        check($sformatf("v%0d_busy", k), 32'(busy), 32'(v.ebusy));
        check($sformatf("v%0d_state", k), 32'(state), 32'(v.ebusy));
        check($sformatf("v%0d_done", k), 32'(burst_done), 32'(v.edone));
        check($sformatf("v%0d_ready", k), 32'(push_ready), 32'(eready));
        check($sformatf("v%0d_pvalid", k), 32'(pop_valid), 32'(v.ebusy && v.vld[v.esrc]));
        check($sformatf("v%0d_pdata", k), pop_data,
              v.ebusy ? {16'(v.esrc), 16'(v.eseq)} : 32'h0);
        check($sformatf("v%0d_pstrb", k), 32'(pop_strb), v.ebusy ? 32'(v.esrc + 1) : 32'h0);
      end
    end

    // Stalls inside a 4-beat burst on stream 1: ready low 3 cycles, then valid low 2 cycles.
    v_pat = 12'b0011_0011_1111;
    r_pat = 12'b1111_1110_0011;
    do_reset(4'd4, 4'h0);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({16'd1, 16'(k)});
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      logic [NB-1:0] eg;
      @(negedge clk);
      push_valid = v_pat[c] ? 4'h2 : 4'h0;
      pop_ready  = r_pat[c];
      #1;
      eg = (c >= 1 && c <= 9) ? 4'h2 : 4'h0;
      check($sformatf("stall_c%0d_grant", c), 32'(grant), 32'(eg));
      check($sformatf("stall_c%0d_done", c), 32'(burst_done), 32'(c == 10));
      check($sformatf("stall_c%0d_ready", c), 32'(push_ready), 32'(r_pat[c] ? eg : 4'h0));
      sb_beat("stall", beats);
    end
    check("stall_beats", 32'(beats), 32'd4);
    check("stall_leftover", 32'(exp_q.size()), 32'd0);

    // burst_len 0 means 16 beats; a mid-burst change to 1 only affects the next burst.
    do_reset(4'd0, 4'h8);
    exp_q.delete();
    for (int k = 0; k < 17; k++) exp_q.push_back({16'd3, 16'(k)});
    beats = 0;
    beats_first = 0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      burst_len  = (c >= 5) ? 4'd1 : 4'd0;
      push_valid = (c <= 18) ? 4'h8 : 4'h0;
      #1;
      check($sformatf("long_c%0d_busy", c), 32'(busy), 32'((c >= 1 && c <= 16) || c == 18));
      check($sformatf("long_c%0d_done", c), 32'(burst_done), 32'(c == 17 || c == 19));
      sb_beat("long", beats);
      if (c == 16) beats_first = beats;
    end
    check("long_first_burst_beats", 32'(beats_first), 32'd16);
    check("long_total_beats", 32'(beats), 32'd17);
    check("long_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_burst_scheduler.md
Name: hwpe_stream_burst_scheduler

Overview:
Round-robin burst scheduler that shares one HWPE output stream among NB_IN requesting input streams. A granted input keeps the output for a configurable number of handshakes before the next arbitration. It sits in front of fenced or shared datapaths and guarantees that bursts are never interleaved. Data path is a combinational mux; grant, counter and round-robin pointer are registered.

Parameters:
NB_IN, 4, number of input streams (>=2)
DATA_WIDTH, 32, stream data width; strb width is DATA_WIDTH/8
BURST_CNT_WIDTH, 8, width of burst length config and beat counter

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
clear_i  input  1  synchronous soft clear, same effect as reset
enable_i  input  1  allows new grants
burst_len_i  input  BURST_CNT_WIDTH  beats per burst; 0 means 2^BURST_CNT_WIDTH
req_mask_i  input  NB_IN  per-stream arbitration enable
push_i  sink  hwpe_stream_intf_stream[NB_IN]  requesting input streams
pop_o  source  hwpe_stream_intf_stream  shared output stream
grant_o  output  NB_IN  one-hot current grant, 0 when idle
busy_o  output  1  high in BURST state
burst_done_o  output  1  one-cycle pulse after the last beat of a burst

Behaviour:
- Reset and clear: one clock, synchronous, active-high reset. rst_i and clear_i both act on the clock edge. Either one forces:
  - state IDLE, grant 0, beat counter 0, burst_done_o 0
  - rr pointer = NB_IN-1, so stream 0 has first priority
  - rst_i takes precedence over clear_i. Both take effect even mid-burst; the open burst is abandoned and no burst_done_o is issued.
- Idle outputs: in IDLE, pop_o.valid=0, pop_o.data=0, pop_o.strb=0, every push_i.ready=0, busy_o=0.
- IDLE state:
  - Request vector = push_i[i].valid & req_mask_i[i].
  - If enable_i=1 and the request vector is nonzero, the winner is the first requester found scanning upward from pointer+1, wrapping modulo NB_IN.
  - At the clock edge: grant_o <= onehot(winner), latched length <= burst_len_i, counter <= 0, state <= BURST.
  - Otherwise remain in IDLE.
- BURST state (grant g):
  - pop_o.valid = push_i[g].valid; pop_o.data and pop_o.strb come from push_i[g].
  - push_i[g].ready = pop_o.ready; all other readys = 0.
  - A handshake (valid & ready) increments the counter.
  - On the handshake where counter == latched_len-1 (latched_len 0 counts as 2^BURST_CNT_WIDTH): state <= IDLE, pointer <= g, grant <= 0, burst_done_o <= 1 for the next cycle.
- Latency: grant is registered, so the first beat can transfer one cycle after the arbitration cycle. Back-to-back bursts have exactly one dead cycle (the IDLE cycle) between the last beat of one burst and the first beat of the next. The burst_done_o pulse coincides with that IDLE cycle.
- Backpressure and invalid inputs: cycles where the granted input is invalid or pop_o.ready is low do not count, and the grant is held indefinitely.
- Config sampling: burst_len_i is sampled only at grant. Changes to enable_i or req_mask_i during BURST do not affect the open burst; a deasserted enable_i only blocks the next grant.
- Invariants: grant_o is always one-hot or zero. A beat on a non-granted input is never forwarded or acknowledged.

Optional Feature:
HWPE_STREAM_BURST_SCHEDULER_PRIO_EN
- Defined: stream 0 has fixed priority. If its request bit is set in IDLE, it wins regardless of the pointer, and the pointer is NOT updated at the end of its burst. Other streams follow round-robin as normal.
- Undefined: pure round-robin as described above, with no priority logic synthesized.

Test Plan:
1. Reset: assert rst_i for 2 cycles with all inputs valid -> grant_o=0, busy_o=0, pop_o.valid=0, all readys 0, burst_done_o=0.
2. NB_IN=4, mask=1111, burst_len_i=3, all inputs always valid, pop_o.ready=1 -> grants cycle 0,1,2,3,0. Each burst is exactly 3 beats with the source's data order, separated by 1 dead cycle; 4 burst_done_o pulses in 16 cycles.
3. Only stream 2 valid, mask=1111, burst_len_i=2 -> stream 2 is granted repeatedly. Mask=1011 blocks stream 2 -> no grant, busy_o stays 0.
4. burst_len_i=4; pop_o.ready low for 3 cycles after beat 1 and the granted valid low for 2 cycles after beat 2 -> still exactly 4 beats, no beat lost or duplicated, burst_done_o only after beat 4.
5. clear_i pulsed after beat 1 of a stream 2 burst -> next cycle grant_o=0 and no burst_done_o. With all inputs valid, the next grant goes to stream 0.
6. BURST_CNT_WIDTH=4, burst_len_i=0 -> burst of 16 beats. burst_len_i changed to 1 mid-burst -> current burst is still 16 beats and the following burst is 1 beat.
